accu_dump_ctrl: RTL
===================

// Module: accu_dump_ctrl
// PURPOSE
//  Integrate-and-dump controller sitting directly downstream of (and wrapped around) the
//  Accumulator. Gates the accumulator's en/clr, counts accepted samples, and every N
//  samples captures the running sum into a valid/ready output register, then clears the
//  accumulator. Turns a free-running sum into a stream of per-frame block sums.
// PARAMETERS
//  W   16  accumulator / output data width (must equal the Accumulator's width)
//  N   8   samples per frame, N >= 1
//  CW  $clog2(N+1)  sample-count width (derived localparam, not overridable)
// PORTS
//  clk        in   1   single clock, all state on rising edge
//  rst        in   1   asynchronous, active-high reset
//  run        in   1   level: enable framing; sampled only in IDLE
//  flush      in   1   pulse: dump partial frame early
//  in_valid   in   1   upstream sample present (data goes straight to Accumulator d)
//  in_ready   out  1   sample accepted this cycle when in_valid & in_ready
//  acc_en     out  1   to Accumulator en; = in_valid & in_ready
//  acc_clr    out  1   to Accumulator clr
//  acc        in   W   Accumulator running sum (registered, reflects en one edge later)
//  out_data   out  W   captured frame sum
//  out_count  out  CW  samples contained in out_data (N, or fewer if flushed)
//  out_partial out 1   1 = frame ended by flush
//  out_valid  out  1   output holding register full
//  out_ready  in   1   downstream accepts when out_valid & out_ready
// BEHAVIOUR
//  Reset (async): state IDLE, count=0, out_valid=0, out_data=0, out_count=0, out_partial=0.
//   The Accumulator is reset by the same rst; no ordering assumed between the two.
//  States IDLE, ACCUM, DUMP (registered FSM):
//  IDLE : acc_clr=1, in_ready=0, acc_en=0. run=1 -> ACCUM (count=0).
//  ACCUM: acc_clr=0, in_ready=1. Each accepted sample count++. Final (N-th) sample accepted
//   -> DUMP. flush=1 with count>0 (incl. a sample accepted same cycle) -> DUMP, partial.
//   flush with count==0 and no sample this cycle: ignored. run ignored in ACCUM.
//  DUMP : in_ready=0, acc_en=0. Slot free = !out_valid | out_ready.
//   Slot free: out_data<=acc, out_count<=count, out_partial<=(count!=N), out_valid<=1,
//   acc_clr=1 this cycle, count<=0; next state ACCUM if run else IDLE.
//   Slot busy: hold in DUMP, acc_clr=0, acc stable (en=0) until slot frees. No data loss.
//  Timing: final sample accepted on edge e -> acc valid during DUMP cycle -> out_valid high
//   after edge e+1 (minimum). Next frame's first sample accepted from the cycle after DUMP.
//   Throughput: N samples per N+1 cycles with no backpressure.
//  Output handshake: out_valid/out_data/out_count/out_partial stable while out_valid &
//   !out_ready. out_ready with no new capture clears out_valid next edge. Accept and
//   capture on same edge: register reloaded, out_valid stays 1.
//  Arithmetic: sum is modulo 2^W (Accumulator wraps); block does no saturation.
//  flush pulse ignored in IDLE and DUMP.
//  in_ready, acc_en, acc_clr are combinational from state/count/in_valid/out_ready; no
//   combinational path from acc to any output.
// TESTING  (W=16, N=4 unless stated)
//  Samples 1,2,3,4 back-to-back, out_ready=1 -> out_data=10, out_count=4, out_partial=0,
//   out_valid one cycle; next frame 5..8 -> 26; in_ready low exactly 1 cycle per frame.
//  in_valid gaps (1,_,2,_,_,3,4) -> out_data=10; count only on accepted samples.
//  Backpressure: out_ready=0 for 6 cycles after frame 10, frame 26 completes -> stays DUMP,
//   in_ready=0, out_data holds 10; out_ready=1 -> 10 then 26 delivered, none lost.
//  Samples 5,6 then flush -> out_data=11, out_count=2, out_partial=1; flush at count 0 ignored.
//  Wrap: four samples 0x8000 -> out_data=0x0000, out_count=4.
//  rst pulse mid-frame (count=2, out_valid=1) -> outputs zero immediately, state IDLE;
//   run=1 -> next frame 1..4 gives 10 (no stale sum).

Source files
------------

// File: rtl/accu_dump_ctrl.sv
// Integrate-and-dump controller: gates an external Accumulator, counts accepted samples and
// hands each frame's sum (N samples, or fewer on flush) to a valid/ready holding register.
module accu_dump_ctrl #(
  parameter int W = 16,
  parameter int N = 8
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            run_i,
  input  logic            flush_i,
  input  logic            in_valid_i,
  output logic            in_ready_o,
  output logic            acc_en_o,
  output logic            acc_clr_o,
  input  logic [W-1:0]    acc_i,
  output logic [W-1:0]    out_data_o,
  output logic [$clog2(N+1)-1:0] out_count_o,
  output logic            out_partial_o,
  output logic            out_valid_o,
  input  logic            out_ready_i
);

  localparam int CW = $clog2(N+1);
  localparam logic [CW-1:0] N_C    = CW'(N);
  localparam logic [CW-1:0] LAST_C = CW'(N - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    DUMP  = 2'd2
  } state_t;

  state_t          state_q, state_d;
  logic [CW-1:0]   count_q, count_d;
  logic [W-1:0]    out_data_q, out_data_d;
  logic [CW-1:0]   out_count_q, out_count_d;
  logic            out_partial_q, out_partial_d;
  logic            out_valid_q, out_valid_d;
  logic            accept_s;
  logic            slot_free_s;

  // Next-state, handshake and accumulator-control decode.
  always_comb begin
    state_d       = state_q;
    count_d       = count_q;
    out_data_d    = out_data_q;
    out_count_d   = out_count_q;
    out_partial_d = out_partial_q;
    out_valid_d   = out_valid_q & ~out_ready_i;
    in_ready_o    = 1'b0;
    acc_en_o      = 1'b0;
    acc_clr_o     = 1'b0;
    accept_s      = 1'b0;
    slot_free_s   = ~out_valid_q | out_ready_i;

    case (state_q)
      IDLE: begin
        acc_clr_o = 1'b1;
        count_d   = {CW{1'b0}};
        if (run_i) begin
          state_d = ACCUM;
        end else begin
          state_d = IDLE;
        end
      end
      ACCUM: begin
        in_ready_o = 1'b1;
        accept_s   = in_valid_i;
        acc_en_o   = accept_s;
        if (accept_s) begin
          count_d = count_q + CW'(1);
        end else begin
          count_d = count_q;
        end
        // A flush only closes a frame that holds at least one sample (possibly this one).
        if (accept_s && (count_q == LAST_C)) begin
          state_d = DUMP;
        end else if (flush_i && ((count_q != {CW{1'b0}}) || accept_s)) begin
          state_d = DUMP;
        end else begin
          state_d = ACCUM;
        end
      end
      DUMP: begin
        if (slot_free_s) begin
          out_data_d    = acc_i;
          out_count_d   = count_q;
          out_partial_d = (count_q != N_C);
          out_valid_d   = 1'b1;
          acc_clr_o     = 1'b1;
          count_d       = {CW{1'b0}};
          if (run_i) begin
            state_d = ACCUM;
          end else begin
            state_d = IDLE;
          end
        end else begin
          state_d = DUMP;
        end
      end
      default: begin
        state_d = IDLE;
        count_d = {CW{1'b0}};
      end
    endcase
  end

  // State, sample counter and output holding register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= IDLE;
      count_q       <= {CW{1'b0}};
      out_data_q    <= {W{1'b0}};
      out_count_q   <= {CW{1'b0}};
      out_partial_q <= 1'b0;
      out_valid_q   <= 1'b0;
    end else begin
      state_q       <= state_d;
      count_q       <= count_d;
      out_data_q    <= out_data_d;
      out_count_q   <= out_count_d;
      out_partial_q <= out_partial_d;
      out_valid_q   <= out_valid_d;
    end
  end

  assign out_data_o    = out_data_q;
  assign out_count_o   = out_count_q;
  assign out_partial_o = out_partial_q;
  assign out_valid_o   = out_valid_q;

endmodule
